writeback: RTL and testbench
============================

// Module: writeback
// PURPOSE
//  Final (WB) pipeline stage. Consumes the MEM-WB register outputs and owns the 32-entry
//  architectural integer register file, with two decode read ports and write-through bypass.
//  Qualifies each incoming slot as a commit, keeps cycle/instret counters and a retire trace,
//  and halts the core on a committed ECALL/EBREAK.
// PARAMETERS
//  XLEN           32  data/address width (from riscv_pkg)
//  NREG           32  architectural registers; x0 hardwired to zero
//  CNT_W          64  width of cycle and instret counters
//  HALT_ON_ECALL  1   1: a committed ECALL/EBREAK enters HALT; 0: treated as a normal commit
// PORTS
//  clk_i             in   1       clock; all state updates on rising edge
//  rst_i             in   1       synchronous reset, active-high
//  pcW_i             in   XLEN    PC of the instruction in WB
//  instrW_i          in   XLEN    instruction word; 32'h0 = bubble
//  rdW_port_i        in   rd_port_t  {addr[4:0], data[XLEN-1:0], valid}: destination writeback
//  stallW_i          in   1       slot is stalled: no commit this cycle
//  flushW_i          in   1       slot is squashed: no commit this cycle
//  rs1_addr_i        in   5       decode read address 1
//  rs2_addr_i        in   5       decode read address 2
//  rs1_data_o        out  XLEN    read data 1 (combinational, bypassed)
//  rs2_data_o        out  XLEN    read data 2 (combinational, bypassed)
//  commit_valid_o    out  1       registered retire strobe
//  commit_pc_o       out  XLEN    PC of the retired instruction
//  commit_instr_o    out  XLEN    retired instruction word
//  commit_rd_we_o    out  1       retired instruction wrote a register
//  commit_rd_addr_o  out  5       destination written
//  commit_rd_data_o  out  XLEN    value written
//  cycle_o           out  CNT_W   cycles since reset while RUN
//  instret_o         out  CNT_W   instructions retired
//  halted_o          out  1       state == HALT
// BEHAVIOUR
//  - commit   = (state==RUN) & (instrW_i!=0) & !stallW_i & !flushW_i.
//  - reg_we   = commit & rdW_port_i.valid & (rdW_port_i.addr!=0). Write lands at the next edge.
//  - Read: addr==0 -> 0. addr==rd.addr & reg_we -> rdW_port_i.data (write-first bypass).
//    Otherwise the regfile content. Both ports bypass independently; equal addresses are allowed.
//  - Trace: commit_* are registered copies of the commit slot, 1-cycle latency.
//    commit_valid_o is a single-cycle pulse per commit. commit_rd_* hold 0 when commit_rd_we_o=0.
//    No commit_* field changes on non-commit cycles except commit_valid_o, which drops to 0.
//  - cycle_o: +1 every cycle in RUN; frozen in HALT. instret_o: +1 per commit.
//    Both wrap from all-ones to 0 with no flag.
//  - FSM wb_state_e {RUN, HALT}. Reset -> RUN.
//    RUN -> HALT when commit & instrW_i in {32'h00000073, 32'h00100073} & HALT_ON_ECALL.
//    The halting instruction itself commits: it counts in instret and pulses the trace.
//    HALT is absorbing until rst_i: no commits, no regfile writes; read ports stay functional.
//  - stallW_i and flushW_i both high -> no commit (same as either alone).
//    A stalled or flushed rd valid never writes.
//  - Reset (any cycle, including mid-stream and in HALT) has priority over all updates. All regs = 0.
//    commit_* = 0, cycle_o = 0, instret_o = 0, halted_o = 0, state = RUN.
//    A commit presented in the reset cycle is dropped.
// STRUCTURE
//  - riscv_pkg additions: wb_state_e, INSTR_ECALL/INSTR_EBREAK constants, commit_t struct
//    {valid, pc, instr, rd_we, rd_addr, rd_data}, REG_ADDR_W=5. rd_port_t is reused unchanged.
//  - Sub-module riscv_regfile: NREG x XLEN, 1 write and 2 async read ports, synchronous
//    active-high clear, x0 forced zero. Bypass lives in the regfile.
//  - The FSM, counters and trace register stay in writeback.
// TESTING
//  1 Reset, then commit instr=32'h00500093, rd{1,32'h5,1}, rs1_addr=1 same cycle ->
//    rs1_data_o=5 (bypass); next cycle commit_valid_o=1, commit_rd_addr_o=1, instret_o=1.
//  2 rd{addr=0, data=32'hDEAD, valid=1} commits -> rs1_addr=0 reads 0; commit_rd_we_o=0.
//  3 Slot with rd{3,32'hAA,1} and stallW_i=1, then flushW_i=1, then instr=0 ->
//    x3 stays 0, no trace pulse, instret_o unchanged, cycle_o +3.
//  4 Commit ECALL 32'h00000073 at pc 32'h100 -> next cycle halted_o=1, commit_pc_o=32'h100,
//    instret_o+1. Further valid slots are ignored and cycle_o is frozen.
//  5 Force instret to all-ones (bench-side force), then commit once -> instret_o=0.
//  6 rst_i pulse in HALT after writing x5=32'h1234 -> halted_o=0, x5 reads 0,
//    counters 0, next commit retires normally.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage and its register file.
package writeback_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic                  valid;
  } rd_port_t;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       instr;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data;
  } commit_t;

endpackage

// File: rtl/writeback_regfile.sv
// Architectural integer register file: 1 write, 2 async read ports with write-first bypass.
module writeback_regfile
  import writeback_pkg::*;
#(
  parameter int unsigned NReg = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]       rdata1_o,
  output logic [XLEN-1:0]       rdata2_o
);

  logic [XLEN-1:0] regs_q [NReg];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NReg; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 check comes last so it overrides any bypass hit.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;

    rdata2_o = regs_q[raddr2_i];
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/writeback.sv
// WB pipeline stage: commit qualification, register file, retire trace, counters, halt FSM.
module writeback
  import writeback_pkg::*;
#(
  parameter int unsigned NREG          = 32,
  parameter int unsigned CNT_W         = 64,
  parameter bit          HALT_ON_ECALL = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [XLEN-1:0]       pcW_i,
  input  logic [XLEN-1:0]       instrW_i,
  input  rd_port_t              rdW_port_i,
  input  logic                  stallW_i,
  input  logic                  flushW_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic                  commit_valid_o,
  output logic [XLEN-1:0]       commit_pc_o,
  output logic [XLEN-1:0]       commit_instr_o,
  output logic                  commit_rd_we_o,
  output logic [REG_ADDR_W-1:0] commit_rd_addr_o,
  output logic [XLEN-1:0]       commit_rd_data_o,
  output logic [CNT_W-1:0]      cycle_o,
  output logic [CNT_W-1:0]      instret_o,
  output logic                  halted_o
);

  wb_state_e        state_q, state_d;
  commit_t          trace_q, trace_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic commit;
  logic reg_we;
  logic is_sys;

  // A slot presented during reset is dropped, so it must not bypass either.
  assign commit = (state_q == StRun) && (instrW_i != '0) && !stallW_i && !flushW_i && !rst_i;
  assign reg_we = commit && rdW_port_i.valid && (rdW_port_i.addr != '0);
  assign is_sys = (instrW_i == INSTR_ECALL) || (instrW_i == INSTR_EBREAK);

  writeback_regfile #(
    .NReg(NREG)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (reg_we),
    .waddr_i (rdW_port_i.addr),
    .wdata_i (rdW_port_i.data),
    .raddr1_i(rs1_addr_i),
    .raddr2_i(rs2_addr_i),
    .rdata1_o(rs1_data_o),
    .rdata2_o(rs2_data_o)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (commit && is_sys && HALT_ON_ECALL) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Trace fields hold between commits; only the valid strobe drops.
  always_comb begin
    trace_d       = trace_q;
    trace_d.valid = 1'b0;
    if (commit) begin
      trace_d.valid   = 1'b1;
      trace_d.pc      = pcW_i;
      trace_d.instr   = instrW_i;
      trace_d.rd_we   = reg_we;
      trace_d.rd_addr = reg_we ? rdW_port_i.addr : '0;
      trace_d.rd_data = reg_we ? rdW_port_i.data : '0;
    end
  end

  always_comb begin
    cycle_d   = (state_q == StRun) ? cycle_q + CNT_W'(1) : cycle_q;
    instret_d = commit ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      trace_q   <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      trace_q   <= trace_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign commit_valid_o   = trace_q.valid;
  assign commit_pc_o      = trace_q.pc;
  assign commit_instr_o   = trace_q.instr;
  assign commit_rd_we_o   = trace_q.rd_we;
  assign commit_rd_addr_o = trace_q.rd_addr;
  assign commit_rd_data_o = trace_q.rd_data;
  assign cycle_o          = cycle_q;
  assign instret_o        = instret_q;
  assign halted_o         = (state_q == StHalt);

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for the writeback stage.
module tb_writeback;
  import writeback_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [XLEN-1:0]       pc, instr;
  rd_port_t              rd;
  logic                  stall, flush;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]       rs1_data, rs2_data;
  logic                  c_valid, c_we, halted;
  logic [XLEN-1:0]       c_pc, c_instr, c_data;
  logic [REG_ADDR_W-1:0] c_addr;
  logic [63:0]           cycle, instret;

  int n_cmp = 0;
  int n_bad = 0;

  writeback dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pcW_i           (pc),
    .instrW_i        (instr),
    .rdW_port_i      (rd),
    .stallW_i        (stall),
    .flushW_i        (flush),
    .rs1_addr_i      (rs1_addr),
    .rs2_addr_i      (rs2_addr),
    .rs1_data_o      (rs1_data),
    .rs2_data_o      (rs2_data),
    .commit_valid_o  (c_valid),
    .commit_pc_o     (c_pc),
    .commit_instr_o  (c_instr),
    .commit_rd_we_o  (c_we),
    .commit_rd_addr_o(c_addr),
    .commit_rd_data_o(c_data),
    .cycle_o         (cycle),
    .instret_o       (instret),
    .halted_o        (halted)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc = '0; instr = '0; rd = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rs1_addr = 5'd1; rs2_addr = 5'd2; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", c_valid); end
    n_cmp++; if (cycle !== 64'd0) begin n_bad++; $display("FAIL reset_cycle: got %0d want 0", cycle); end
    n_cmp++; if (instret !== 64'd0) begin n_bad++; $display("FAIL reset_instret: got %0d want 0", instret); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL reset_x1: got %h want 0", rs1_data); end
  endtask

  task automatic test_bypass();
    pc = 32'h0; instr = 32'h0050_0093; rd = '{addr: 5'd1, data: 32'h5, valid: 1'b1};
    rs1_addr = 5'd1; rs2_addr = 5'd1;
    #1;
    n_cmp++; if (rs1_data !== 32'h5) begin n_bad++; $display("FAIL byp_rs1: got %h want 5", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h5) begin n_bad++; $display("FAIL byp_rs2: got %h want 5", rs2_data); end
    step(); idle();
    #1;
    n_cmp++; if (c_valid !== 1'b1) begin n_bad++; $display("FAIL t1_valid: got %0b want 1", c_valid); end
    n_cmp++; if (c_addr !== 5'd1) begin n_bad++; $display("FAIL t1_rd_addr: got %0d want 1", c_addr); end
    n_cmp++; if (c_data !== 32'h5) begin n_bad++; $display("FAIL t1_rd_data: got %h want 5", c_data); end
    n_cmp++; if (instret !== 64'd1) begin n_bad++; $display("FAIL t1_instret: got %0d want 1", instret); end
    n_cmp++; if (cycle !== 64'd1) begin n_bad++; $display("FAIL t1_cycle: got %0d want 1", cycle); end
    n_cmp++; if (rs1_data !== 32'h5) begin n_bad++; $display("FAIL t1_x1_stored: got %h want 5", rs1_data); end
    step();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL t1_pulse: got %0b want 0", c_valid); end
  endtask

  task automatic test_x0();
    pc = 32'h4; instr = 32'h0000_0013; rd = '{addr: 5'd0, data: 32'hDEAD, valid: 1'b1};
    rs1_addr = 5'd0;
    #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x0_read: got %h want 0", rs1_data); end
    step(); idle();
    n_cmp++; if (c_valid !== 1'b1) begin n_bad++; $display("FAIL x0_valid: got %0b want 1", c_valid); end
    n_cmp++; if (c_we !== 1'b0) begin n_bad++; $display("FAIL x0_we: got %0b want 0", c_we); end
    n_cmp++; if (c_data !== 32'h0) begin n_bad++; $display("FAIL x0_data: got %h want 0", c_data); end
    n_cmp++; if (instret !== 64'd2) begin n_bad++; $display("FAIL x0_instret: got %0d want 2", instret); end
  endtask

  task automatic test_no_commit();
    logic [63:0] c0, i0;
    c0 = cycle; i0 = instret;
    pc = 32'h8; instr = 32'h0AA0_0193; rd = '{addr: 5'd3, data: 32'hAA, valid: 1'b1};
    rs1_addr = 5'd3; stall = 1'b1;
    #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL stall_byp: got %h want 0", rs1_data); end
    step();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid: got %0b want 0", c_valid); end
    stall = 1'b0; flush = 1'b1;
    step();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0b want 0", c_valid); end
    stall = 1'b1;
    step();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL both_valid: got %0b want 0", c_valid); end
    stall = 1'b0; flush = 1'b0; instr = 32'h0;
    step();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL bubble_valid: got %0b want 0", c_valid); end
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL x3_unwritten: got %h want 0", rs1_data); end
    n_cmp++; if (instret !== i0) begin n_bad++; $display("FAIL nc_instret: got %0d want %0d", instret, i0); end
    n_cmp++; if (cycle !== c0 + 64'd4) begin n_bad++; $display("FAIL nc_cycle: got %0d want %0d", cycle, c0 + 64'd4); end
    n_cmp++; if (c_pc !== 32'h4) begin n_bad++; $display("FAIL nc_pc_held: got %h want 4", c_pc); end
    idle();
  endtask

  task automatic test_halt();
    logic [63:0] c0, i0;
    pc = 32'hC; instr = 32'h1234_0293; rd = '{addr: 5'd5, data: 32'h1234, valid: 1'b1};
    step();
    i0 = instret;
    pc = 32'h100; instr = INSTR_ECALL; rd = '0;
    step(); idle();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ecall_halted: got %0b want 1", halted); end
    n_cmp++; if (c_pc !== 32'h100) begin n_bad++; $display("FAIL ecall_pc: got %h want 100", c_pc); end
    n_cmp++; if (c_valid !== 1'b1) begin n_bad++; $display("FAIL ecall_valid: got %0b want 1", c_valid); end
    n_cmp++; if (instret !== i0 + 64'd1) begin n_bad++; $display("FAIL ecall_instret: got %0d want %0d", instret, i0 + 64'd1); end
    c0 = cycle;
    pc = 32'h104; instr = 32'h0660_0313; rd = '{addr: 5'd6, data: 32'h66, valid: 1'b1};
    rs1_addr = 5'd6; rs2_addr = 5'd5;
    #1;
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL halt_byp: got %h want 0", rs1_data); end
    step(); step(); idle();
    n_cmp++; if (c_valid !== 1'b0) begin n_bad++; $display("FAIL halt_valid: got %0b want 0", c_valid); end
    n_cmp++; if (cycle !== c0) begin n_bad++; $display("FAIL halt_cycle: got %0d want %0d", cycle, c0); end
    n_cmp++; if (instret !== i0 + 64'd1) begin n_bad++; $display("FAIL halt_instret: got %0d want %0d", instret, i0 + 64'd1); end
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL halt_x6: got %h want 0", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h1234) begin n_bad++; $display("FAIL halt_x5: got %h want 1234", rs2_data); end
    n_cmp++; if (c_pc !== 32'h100) begin n_bad++; $display("FAIL halt_pc_held: got %h want 100", c_pc); end
  endtask

  task automatic test_reset_in_halt();
    rst = 1'b1;
    pc = 32'h1F0; instr = 32'h0770_0393; rd = '{addr: 5'd7, data: 32'h77, valid: 1'b1};
    step();
    rst = 1'b0; idle(); rs1_addr = 5'd5; rs2_addr = 5'd7;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %0b want 0", halted); end
    n_cmp++; if (rs1_data !== 32'h0) begin n_bad++; $display("FAIL rst_x5: got %h want 0", rs1_data); end
    n_cmp++; if (rs2_data !== 32'h0) begin n_bad++; $display("FAIL rst_x7_dropped: got %h want 0", rs2_data); end
    n_cmp++; if (cycle !== 64'd0) begin n_bad++; $display("FAIL rst_cycle: got %0d want 0", cycle); end
    n_cmp++; if (instret !== 64'd0) begin n_bad++; $display("FAIL rst_instret: got %0d want 0", instret); end
    n_cmp++; if (c_valid !== 1'b0 || c_pc !== 32'h0) begin n_bad++; $display("FAIL rst_trace: got %0b/%h want 0/0", c_valid, c_pc); end
    pc = 32'h200; instr = 32'h0070_0393; rd = '{addr: 5'd7, data: 32'h7, valid: 1'b1};
    step(); idle();
    n_cmp++; if (c_valid !== 1'b1 || c_pc !== 32'h200) begin n_bad++; $display("FAIL post_rst_commit: got %0b/%h want 1/200", c_valid, c_pc); end
    n_cmp++; if (instret !== 64'd1) begin n_bad++; $display("FAIL post_rst_instret: got %0d want 1", instret); end
    n_cmp++; if (rs2_data !== 32'h7) begin n_bad++; $display("FAIL post_rst_x7: got %h want 7", rs2_data); end
  endtask

  task automatic test_wrap_and_ebreak();
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    pc = 32'h204; instr = 32'h0000_0013; rd = '0;
    step(); idle();
    n_cmp++; if (instret !== 64'd0) begin n_bad++; $display("FAIL wrap_instret: got %h want 0", instret); end
    pc = 32'h208; instr = INSTR_EBREAK;
    step(); idle();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ebreak_halted: got %0b want 1", halted); end
    n_cmp++; if (c_instr !== INSTR_EBREAK) begin n_bad++; $display("FAIL ebreak_instr: got %h want %h", c_instr, INSTR_EBREAK); end
    n_cmp++; if (instret !== 64'd1) begin n_bad++; $display("FAIL ebreak_instret: got %0d want 1", instret); end
  endtask

  initial begin
    idle(); rst = 1'b1; rs1_addr = '0; rs2_addr = '0;
    test_reset();
    test_bypass();
    test_x0();
    test_no_commit();
    test_halt();
    test_reset_in_halt();
    test_wrap_and_ebreak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
